// File: rtl/ufp_line_responder.sv
// Single-line responder for the ufp word interface: serves 32-bit reads/writes from one
// cached line, fetching over dfp on a miss and writing every store through to dfp.
module ufp_line_responder #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  ufp_addr,
  input  logic [3:0]                   ufp_rmask,
  input  logic [3:0]                   ufp_wmask,
  input  logic [31:0]                  ufp_wdata,
  output logic                         ufp_resp,
  output logic [31:0]                  ufp_rdata,
  output logic [31:0]                  dfp_addr,
  output logic                         dfp_read,
  output logic                         dfp_write,
  output logic [32*LINE_WORDS-1:0]     dfp_wdata,
  input  logic [32*LINE_WORDS-1:0]     dfp_rdata,
  input  logic                         dfp_resp,
  output logic                         proto_err
);

  localparam int unsigned OFFW = $clog2(LINE_WORDS);
  localparam int unsigned TAGW = 30 - OFFW;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  typedef enum logic [1:0] {IDLE, FETCH, WB, RESP} state_t;

  state_t            state_q;
  logic              valid_q;
  logic [TAGW-1:0]   tag_q;
  line_t             line_q;

  logic [TAGW-1:0]   req_tag_q;
  logic [OFFW-1:0]   req_off_q;
  logic [3:0]        req_wmask_q;
  logic [31:0]       req_wdata_q;
  logic              req_write_q;

  logic              ufp_resp_q;
  logic [31:0]       ufp_rdata_q;
  logic [31:0]       dfp_addr_q;
  logic              dfp_read_q;
  logic              dfp_write_q;
  line_t             dfp_wdata_q;
  logic              proto_err_q;

  logic              req;
  logic              is_write;
  logic              hit;
  logic [OFFW-1:0]   in_off;
  logic [TAGW-1:0]   in_tag;
  line_t             fetched;
  line_t             hit_line_d;
  line_t             fill_line_d;
  logic              unused_addr_bits;

  function automatic line_t merge_word(input line_t l, input logic [OFFW-1:0] off,
                                       input logic [3:0] m, input logic [31:0] d);
    merge_word = l;
    for (int unsigned b = 0; b < 4; b++) begin
      if (m[b]) merge_word[off][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  assign in_off           = ufp_addr[OFFW+1:2];
  assign in_tag           = ufp_addr[31:OFFW+2];
  assign unused_addr_bits = ^ufp_addr[1:0];
  assign fetched          = dfp_rdata;

  always_comb begin
    req         = (|ufp_rmask) | (|ufp_wmask);
    is_write    = |ufp_wmask;
    hit         = valid_q && (tag_q == in_tag);
    hit_line_d  = merge_word(line_q, in_off, ufp_wmask, ufp_wdata);
    fill_line_d = merge_word(fetched, req_off_q, req_wmask_q, req_wdata_q);
  end

  // Hit decisions are taken on the incoming address so a read hit answers next cycle;
  // the byte merge lands in line_q as WB is entered, so a request accepted in RESP
  // already sees the updated line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      line_q      <= '0;
      req_tag_q   <= '0;
      req_off_q   <= '0;
      req_wmask_q <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      ufp_resp_q  <= 1'b0;
      ufp_rdata_q <= '0;
      dfp_addr_q  <= '0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      dfp_wdata_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          ufp_resp_q  <= 1'b0;
          ufp_rdata_q <= '0;
          state_q     <= IDLE;
          if (req) begin
            req_tag_q   <= in_tag;
            req_off_q   <= in_off;
            req_wmask_q <= ufp_wmask;
            req_wdata_q <= ufp_wdata;
            req_write_q <= is_write;
            dfp_addr_q  <= {in_tag, {(OFFW+2){1'b0}}};
            if (!hit) begin
              dfp_read_q <= 1'b1;
              state_q    <= FETCH;
            end else if (is_write) begin
              line_q      <= hit_line_d;
              dfp_wdata_q <= hit_line_d;
              dfp_write_q <= 1'b1;
              state_q     <= WB;
            end else begin
              ufp_resp_q  <= 1'b1;
              ufp_rdata_q <= line_q[in_off];
              state_q     <= RESP;
            end
          end
        end
        FETCH: begin
          if (req) proto_err_q <= 1'b1;
          if (dfp_resp) begin
            dfp_read_q <= 1'b0;
            valid_q    <= 1'b1;
            tag_q      <= req_tag_q;
            if (req_write_q) begin
              line_q      <= fill_line_d;
              dfp_wdata_q <= fill_line_d;
              dfp_write_q <= 1'b1;
              state_q     <= WB;
            end else begin
              line_q      <= fetched;
              ufp_resp_q  <= 1'b1;
              ufp_rdata_q <= fetched[req_off_q];
              state_q     <= RESP;
            end
          end
        end
        WB: begin
          if (req) proto_err_q <= 1'b1;
          if (dfp_resp) begin
            dfp_write_q <= 1'b0;
            ufp_resp_q  <= 1'b1;
            ufp_rdata_q <= '0;
            state_q     <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ufp_resp  = ufp_resp_q;
  assign ufp_rdata = ufp_rdata_q;
  assign dfp_addr  = dfp_addr_q;
  assign dfp_read  = dfp_read_q;
  assign dfp_write = dfp_write_q;
  assign dfp_wdata = dfp_wdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ufp_line_responder.sv
// Directed bench for ufp_line_responder: stimulus pushes expected read data into a
// scoreboard queue; a monitor pops and compares on every ufp_resp cycle.
module tb_ufp_line_responder;

  typedef logic [7:0][31:0] line_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   ufp_addr = '0;
  logic [3:0]    ufp_rmask = '0;
  logic [3:0]    ufp_wmask = '0;
  logic [31:0]   ufp_wdata = '0;
  logic          ufp_resp;
  logic [31:0]   ufp_rdata;
  logic [31:0]   dfp_addr;
  logic          dfp_read;
  logic          dfp_write;
  logic [255:0]  dfp_wdata;
  logic [255:0]  dfp_rdata = '0;
  logic          dfp_resp = 1'b0;
  logic          proto_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  ufp_line_responder #(.LINE_WORDS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ufp_addr  (ufp_addr),
    .ufp_rmask (ufp_rmask),
    .ufp_wmask (ufp_wmask),
    .ufp_wdata (ufp_wdata),
    .ufp_resp  (ufp_resp),
    .ufp_rdata (ufp_rdata),
    .dfp_addr  (dfp_addr),
    .dfp_read  (dfp_read),
    .dfp_write (dfp_write),
    .dfp_wdata (dfp_wdata),
    .dfp_rdata (dfp_rdata),
    .dfp_resp  (dfp_resp),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per response cycle; rdata must be 0 outside responses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ufp_resp) begin
        chk("resp_has_expectation", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("ufp_rdata", ufp_rdata, exp_q.pop_front());
      end else begin
        chk("rdata_zero_without_resp", ufp_rdata, 0);
      end
      chk("dfp_rw_exclusive", dfp_read && dfp_write, 0);
    end
  end

  // Caller sits 1 time unit after a rising edge; request is held for exactly one cycle.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd);
    ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
    @(posedge clk); #1;
    ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic dfp_serve(input bit is_wr, input logic [31:0] exp_addr, input line_t rline,
                           input line_t exp_wline, input int hold);
    int n;
    n = 0;
    while (!(dfp_read || dfp_write) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dfp_request_seen", dfp_read | dfp_write, 1);
    chk("dfp_write_dir", dfp_write, is_wr);
    chk("dfp_read_dir", dfp_read, !is_wr);
    chk("dfp_addr", dfp_addr, exp_addr);
    if (is_wr) chk("dfp_wdata", dfp_wdata, exp_wline);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("dfp_held", is_wr ? dfp_write : dfp_read, 1);
      chk("dfp_addr_stable", dfp_addr, exp_addr);
    end
    dfp_rdata = rline;
    dfp_resp  = 1'b1;
    @(posedge clk); #1;
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    chk("dfp_dropped_after_resp", is_wr ? dfp_write : dfp_read, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ufp_resp"}, ufp_resp, 0);
    chk({tag, "_ufp_rdata"}, ufp_rdata, 0);
    chk({tag, "_dfp_addr"}, dfp_addr, 0);
    chk({tag, "_dfp_read"}, dfp_read, 0);
    chk({tag, "_dfp_write"}, dfp_write, 0);
    chk({tag, "_dfp_wdata"}, dfp_wdata, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    line_t lineA, lineAw, lineB, lineBw, lineC, lineD;
    for (int i = 0; i < 8; i++) begin
      lineA[i] = 32'h1100_0000 + i;
      lineB[i] = 32'h2200_0000 + i;
      lineC[i] = 32'h3300_0000 + i;
      lineD[i] = 32'h4400_0000 + i;
    end
    lineA[1]  = 32'hDEAD_BEEF;
    lineAw    = lineA;
    lineAw[1] = 32'hDEAD_1234;
    lineBw    = lineB;
    lineBw[0] = 32'hCAFE_F00D;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle_cycle();
    chk_all_zero("post_reset");

    // 1: cold read miss
    exp_q.push_back(32'hDEAD_BEEF);
    do_req(32'h1000_0024, 4'hF, 4'h0, '0);
    dfp_serve(1'b0, 32'h1000_0020, lineA, '0, 2);
    chk("t1_resp_after_dfp", ufp_resp, 1);

    // 2: read hit, issued in the response cycle of test 1
    exp_q.push_back(32'hDEAD_BEEF);
    do_req(32'h1000_0024, 4'hF, 4'h0, '0);
    chk("t2_hit_latency", ufp_resp, 1);
    chk("t2_no_dfp", dfp_read | dfp_write, 0);

    // 5a: back-to-back read in the response cycle of test 2
    exp_q.push_back(32'h1100_0000);
    do_req(32'h1000_0020, 4'hF, 4'h0, '0);
    chk("t5_b2b_latency", ufp_resp, 1);
    idle_cycle();
    chk("resp_single_cycle", ufp_resp, 0);

    // 3: write hit, then read back issued in the write's response cycle
    exp_q.push_back(32'h0);
    do_req(32'h1000_0024, 4'h0, 4'h3, 32'h0000_1234);
    chk("t3_wb_latency", dfp_write, 1);
    chk("t3_word1", dfp_wdata[63:32], 32'hDEAD_1234);
    dfp_serve(1'b1, 32'h1000_0020, '0, lineAw, 1);
    chk("t3_resp_after_dfp", ufp_resp, 1);
    exp_q.push_back(32'hDEAD_1234);
    do_req(32'h1000_0024, 4'hF, 4'h0, '0);
    chk("t3_readback_hit", ufp_resp, 1);
    idle_cycle();

    // 4: write miss -> FETCH, WB, RESP
    exp_q.push_back(32'h0);
    do_req(32'h2000_0000, 4'h0, 4'hF, 32'hCAFE_F00D);
    dfp_serve(1'b0, 32'h2000_0000, lineB, '0, 1);
    chk("t4_wb_follows_fetch", dfp_write, 1);
    chk("t4_no_resp_yet", ufp_resp, 0);
    dfp_serve(1'b1, 32'h2000_0000, '0, lineBw, 0);
    chk("t4_resp_after_wb", ufp_resp, 1);
    chk("t4_proto_err_clear", proto_err, 0);
    exp_q.push_back(32'h2200_0007);
    do_req(32'h2000_001C, 4'hF, 4'h0, '0);
    chk("t4_new_line_hit", ufp_resp, 1);
    idle_cycle();

    // 5b: request during FETCH is dropped and flags proto_err
    exp_q.push_back(32'h3300_0002);
    do_req(32'h3000_0048, 4'hF, 4'h0, '0);
    chk("t5_fetch_started", dfp_read, 1);
    do_req(32'h2000_0000, 4'hF, 4'h0, '0);
    chk("t5_proto_err_set", proto_err, 1);
    dfp_serve(1'b0, 32'h3000_0040, lineC, '0, 0);
    chk("t5_resp_after_dfp", ufp_resp, 1);
    idle_cycle();

    // Stray dfp_resp while idle is ignored
    dfp_resp = 1'b1;
    idle_cycle();
    dfp_resp = 1'b0;
    chk("stray_idle_no_resp", ufp_resp, 0);
    chk("stray_idle_no_dfp", dfp_read | dfp_write, 0);
    chk("proto_err_sticky", proto_err, 1);

    // 6: reset mid-FETCH
    do_req(32'h4000_0000, 4'hF, 4'h0, '0);
    chk("t6_fetch_started", dfp_read, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dfp_rdata = lineC;
    dfp_resp  = 1'b1;
    idle_cycle();
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    chk("t6_stray_no_resp", ufp_resp, 0);
    chk("t6_stray_no_dfp", dfp_read | dfp_write, 0);
    idle_cycle();
    chk("t6_stray_no_resp_later", ufp_resp, 0);

    // Line was invalidated by reset: former hit address must miss
    exp_q.push_back(32'h4400_0002);
    do_req(32'h3000_0048, 4'hF, 4'h0, '0);
    chk("t6_valid_cleared_miss", dfp_read, 1);
    dfp_serve(1'b0, 32'h3000_0040, lineD, '0, 0);
    chk("t6_resp_after_refetch", ufp_resp, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
